// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the shared single-port data memory.
// Master 1 (loader) may hold a bounded lock; read data returns one cycle after grant.
module dmem_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_req,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_we,
    output logic            m0_gnt,
    output logic            cpu_stall,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_req,
    input  logic            m1_lock,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_we,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic            mem_en,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_we,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = 4;

    logic          last;
    logic          locked;
    logic [CW-1:0] burst_cnt;
    logic          pend0;
    logic          pend1;
    logic          lock_open;

    assign lock_open = locked && (burst_cnt < CW'(BURST_MAX));

    // Grant selection: single requester wins, else lock then round-robin.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!reset) begin
            if (m0_req && m1_req) begin
                if (lock_open || !last) begin
                    m1_gnt = 1'b1;
                end else begin
                    m0_gnt = 1'b1;
                end
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    // Memory port mux; zero when idle.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = '0;
        if (m0_gnt) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_we    = m0_we;
        end else if (m1_gnt) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_we;
        end
    end

    assign mem_en    = m0_gnt | m1_gnt;
    assign cpu_stall = !reset && m0_req && !m0_gnt;

    // Pending reads are squashed while reset is high so they never reach a master.
    assign m0_rvalid = pend0 && !reset;
    assign m1_rvalid = pend1 && !reset;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            last      <= 1'b1;
            locked    <= 1'b0;
            burst_cnt <= '0;
            pend0     <= 1'b0;
            pend1     <= 1'b0;
        end else begin
            pend0 <= m0_gnt && (m0_we == BW'(0));
            pend1 <= m1_gnt && (m1_we == BW'(0));
            if (m0_gnt) begin
                last      <= 1'b0;
                locked    <= 1'b0;
                burst_cnt <= '0;
            end else if (m1_gnt) begin
                last <= 1'b1;
                if (m1_lock) begin
                    locked <= 1'b1;
                    if (burst_cnt < CW'(BURST_MAX)) begin
                        burst_cnt <= burst_cnt + CW'(1);
                    end
                end else begin
                    locked    <= 1'b0;
                    burst_cnt <= '0;
                end
            end else if (locked && !m1_req) begin
                // Loader walked away from its lock: end the episode.
                locked    <= 1'b0;
                burst_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a cycle model of the arbitration rules checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

    localparam int unsigned AW        = 32;
    localparam int unsigned DW        = 32;
    localparam int unsigned BW        = DW / 8;
    localparam int          BURST_MAX = 4;
    localparam logic [DW-1:0] JUNK    = 32'hBAD0_BAD0;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m1_req, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [BW-1:0] m0_we, m1_we;
    logic          m0_gnt, m1_gnt, cpu_stall, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_we;
    logic [DW-1:0] mem_rdata = JUNK;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_gnt(m0_gnt), .cpu_stall(cpu_stall), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_we(m1_we), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dm_hash(input logic [AW-1:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // DMEM stand-in: synchronous read returns a per-address pattern, junk otherwise.
    logic          dm_rd;
    logic [AW-1:0] dm_addr;
    always @(negedge clk) begin
        dm_rd   = mem_en && (mem_we == '0);
        dm_addr = mem_addr;
    end
    always @(posedge clk) mem_rdata <= dm_rd ? dm_hash(dm_addr) : JUNK;

    // Reference model: owner of the port this cycle, then state for the next cycle.
    int            mdl_last = 1;
    int            mdl_run  = 0;
    bit            mdl_lock = 1'b0;
    int            rd_owner = -1;
    logic [AW-1:0] rd_addr  = '0;

    always @(negedge clk) begin
        int w;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [BW-1:0] e_we;
        bit e_rv0, e_rv1;
        if (reset || (!m0_req && !m1_req)) w = -1;
        else if (m0_req != m1_req)          w = m1_req ? 1 : 0;
        else if (mdl_lock && mdl_run < BURST_MAX) w = 1;
        else                                w = 1 - mdl_last;

        e_addr  = (w == 0) ? m0_addr  : (w == 1) ? m1_addr  : '0;
        e_wdata = (w == 0) ? m0_wdata : (w == 1) ? m1_wdata : '0;
        e_we    = (w == 0) ? m0_we    : (w == 1) ? m1_we    : '0;
        e_rv0   = !reset && rd_owner == 0;
        e_rv1   = !reset && rd_owner == 1;

        chk("m0_gnt", 64'(m0_gnt), 64'(w == 0));
        chk("m1_gnt", 64'(m1_gnt), 64'(w == 1));
        chk("mem_en", 64'(mem_en), 64'(w >= 0));
        chk("mem_addr", 64'(mem_addr), 64'(e_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
        chk("mem_we", 64'(mem_we), 64'(e_we));
        chk("cpu_stall", 64'(cpu_stall), 64'(!reset && m0_req && w != 0));
        chk("m0_rvalid", 64'(m0_rvalid), 64'(e_rv0));
        chk("m1_rvalid", 64'(m1_rvalid), 64'(e_rv1));
        chk("m0_rdata", 64'(m0_rdata), e_rv0 ? 64'(dm_hash(rd_addr)) : 64'(0));
        chk("m1_rdata", 64'(m1_rdata), e_rv1 ? 64'(dm_hash(rd_addr)) : 64'(0));

        if (reset) begin
            mdl_last = 1; mdl_lock = 1'b0; mdl_run = 0; rd_owner = -1;
        end else begin
            rd_owner = -1;
            if (w >= 0 && e_we == '0) begin
                rd_owner = w;
                rd_addr  = e_addr;
            end
            if (w == 0) begin
                mdl_last = 0; mdl_lock = 1'b0; mdl_run = 0;
            end else if (w == 1 && m1_lock) begin
                mdl_last = 1; mdl_lock = 1'b1;
                if (mdl_run < BURST_MAX) mdl_run++;
            end else if (w == 1 || !m1_req) begin
                if (w == 1) mdl_last = 1;
                mdl_lock = 1'b0; mdl_run = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [BW-1:0] we);
        m0_req = r; m0_addr = a; m0_wdata = d; m0_we = we;
    endtask

    task automatic set_m1(input logic r, input logic l, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] we);
        m1_req = r; m1_lock = l; m1_addr = a; m1_wdata = d; m1_we = we;
    endtask

    initial begin
        reset = 1'b1;
        set_m0(1'b1, 32'h100, '0, '0);
        set_m1(1'b1, 1'b0, 32'h200, '0, '0);

        // Reset held two cycles with both masters requesting.
        @(posedge clk); #3;
        chk("rst_g0", 64'(m0_gnt), 64'd0);
        chk("rst_g1", 64'(m1_gnt), 64'd0);
        chk("rst_en", 64'(mem_en), 64'd0);
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        chk("rst_rv1", 64'(m1_rvalid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; #2;
        chk("rr_c1_g0", 64'(m0_gnt), 64'd1);

        // Round-robin reads, data routed to the right master.
        cyc(); #2;
        chk("rr_c2_g1", 64'(m1_gnt), 64'd1);
        chk("rr_c2_rd0", 64'(m0_rdata), 64'hFEFF_0100);
        cyc(); #2;
        chk("rr_c3_g0", 64'(m0_gnt), 64'd1);
        chk("rr_c3_rd1", 64'(m1_rdata), 64'hFDFF_0200);
        chk("rr_c3_rv0", 64'(m0_rvalid), 64'd0);
        cyc(); #2;
        chk("rr_c4_g1", 64'(m1_gnt), 64'd1);

        // Locked burst: m0 wins once, then m1 holds four grants, then m0 forced.
        cyc(); m1_lock = 1'b1; #2;
        chk("lk_first_g0", 64'(m0_gnt), 64'd1);
        for (int i = 0; i < BURST_MAX; i++) begin
            cyc(); #2;
            chk("lk_burst_g1", 64'(m1_gnt), 64'd1);
            chk("lk_burst_stall", 64'(cpu_stall), 64'd1);
        end
        cyc(); #2;
        chk("lk_forced_g0", 64'(m0_gnt), 64'd1);

        // m0 idle: m1 keeps the port while the count saturates.
        cyc(); m0_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #2; chk("sat_g1", 64'(m1_gnt), 64'd1);
            cyc();
        end
        m0_req = 1'b1; #2;
        chk("sat_g0", 64'(m0_gnt), 64'd1);

        // Uncontended byte-masked write.
        cyc();
        set_m1(1'b0, 1'b0, 32'h200, '0, '0);
        set_m0(1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011); #2;
        chk("wr_en", 64'(mem_en), 64'd1);
        chk("wr_we", 64'(mem_we), 64'h3);
        chk("wr_addr", 64'(mem_addr), 64'h40);
        chk("wr_data", 64'(mem_wdata), 64'hDEAD_BEEF);
        cyc();
        set_m0(1'b0, 32'h100, '0, '0);
        set_m1(1'b1, 1'b1, 32'h300, '0, '0); #2;
        chk("wr_no_rv0", 64'(m0_rvalid), 64'd0);
        chk("rm_g1", 64'(m1_gnt), 64'd1);

        // Reset right after a locked m1 read: data dropped, lock gone.
        cyc(); reset = 1'b1; m0_req = 1'b1; #2;
        chk("rm_rv1", 64'(m1_rvalid), 64'd0);
        chk("rm_rd1", 64'(m1_rdata), 64'd0);
        cyc(); reset = 1'b0; #2;
        chk("rm_after_g0", 64'(m0_gnt), 64'd1);
        cyc(); #2;
        chk("rm_next_g1", 64'(m1_gnt), 64'd1);

        // Lock release by dropping request while m0 waits.
        cyc(); m0_req = 1'b0;
        cyc(); m0_req = 1'b1; #2;
        chk("dr_locked_g1", 64'(m1_gnt), 64'd1);
        cyc(); m1_req = 1'b0; #2;
        chk("dr_g0", 64'(m0_gnt), 64'd1);
        cyc(); m1_req = 1'b1; #2;
        chk("dr_rr_g1", 64'(m1_gnt), 64'd1);

        // Drop with nobody else waiting still ends the lock.
        cyc(); m0_req = 1'b0;
        cyc(); m1_req = 1'b0;
        cyc(); m0_req = 1'b1; m1_req = 1'b1; #2;
        chk("dr_idle_g0", 64'(m0_gnt), 64'd1);

        // Mixed traffic checked by the model alone.
        for (int i = 0; i < 80; i++) begin
            cyc();
            set_m0(1'($urandom_range(0, 1)), AW'($urandom_range(0, 255) * 4),
                   DW'($urandom), ($urandom_range(0, 2) == 0) ? BW'($urandom) : '0);
            set_m1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                   AW'(32'h1000 + $urandom_range(0, 255) * 4), DW'($urandom),
                   ($urandom_range(0, 2) == 0) ? BW'($urandom) : '0);
        end
        cyc();
        set_m0(1'b0, '0, '0, '0);
        set_m1(1'b0, 1'b0, '0, '0, '0);
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
